// File: rtl/fp_result_writeback.sv
// FP adder result writeback queue: NaN-boxes single results, buffers them in a
// small FIFO ahead of the register file, and accrues sticky exception flags.
module fp_result_writeback #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_result,
  input  logic             in_is_dp,
  input  logic [4:0]       in_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             csr_we,
  input  logic [4:0]       csr_wdata,
  output logic [4:0]       fflags,
  output logic [15:0]      commit_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  logic [63:0]      r_mem_res [DEPTH];
  logic [4:0]       r_mem_flg [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [4:0]       r_fflags;
  logic [15:0]      r_commit;

  logic             w_push, w_pop;
  logic [63:0]      w_boxed;

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_boxed   = in_is_dp ? in_result : {32'hFFFF_FFFF, in_result[31:0]};

  // Head is read straight from storage so out_* never sees in_* in the push cycle.
  assign out_result   = r_mem_res[r_rd_ptr];
  assign out_flags    = r_mem_flg[r_rd_ptr];
  assign out_tag      = r_mem_tag[r_rd_ptr];
  assign fflags       = r_fflags;
  assign commit_count = r_commit;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_res[r_wr_ptr] <= w_boxed;
      r_mem_flg[r_wr_ptr] <= in_flags;
      r_mem_tag[r_wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A CSR write in the same cycle as a commit keeps the committing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags <= '0;
      r_commit <= '0;
    end else begin
      if (csr_we)     r_fflags <= csr_wdata | (w_pop ? out_flags : 5'b0);
      else if (w_pop) r_fflags <= r_fflags | out_flags;
      if (w_pop)      r_commit <= r_commit + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_result_writeback.sv
// Directed bench for fp_result_writeback: boxing, ordering, backpressure,
// flag accrual, flush and asynchronous reset.
module tb_fp_result_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_dp;
  logic [63:0] in_result;
  logic [4:0]  in_flags;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_flags, out_tag;
  logic        flush, csr_we;
  logic [4:0]  csr_wdata, fflags;
  logic [15:0] commit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_result_writeback #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_is_dp(in_is_dp), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag),
    .flush(flush), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .fflags(fflags), .commit_count(commit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cfg(input logic dp, input logic [63:0] res,
                          input logic [4:0] flg, input logic [4:0] tag);
    in_valid  = 1'b1;
    in_is_dp  = dp;
    in_result = res;
    in_flags  = flg;
    in_tag    = tag;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if (fflags !== 5'b0 || commit_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: fflags=%b commit=%0d want 0/0", fflags, commit_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    push_cfg(1'b0, 64'h0000_0000_3F80_0000, 5'b00001, 5'd3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: out_valid=%b want 0 in push cycle", out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_3F80_0000 ||
        out_flags !== 5'b00001 || out_tag !== 5'd3) begin
      errors++;
      $display("FAIL single_head: v=%b res=%h flg=%b tag=%0d want 1 ffffffff3f800000 00001 3",
               out_valid, out_result, out_flags, out_tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fflags !== 5'b00001 || commit_count !== 16'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: fflags=%b commit=%0d v=%b want 00001 1 0",
               fflags, commit_count, out_valid);
    end
  endtask

  task automatic test_dp_and_hold();
    push_cfg(1'b1, 64'h4000_0000_0000_0000, 5'b00000, 5'd7);
    tick();
    push_cfg(1'b0, 64'hDEAD_BEEF_4000_0000, 5'b00100, 5'd8);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_tag !== 5'd7 || out_result !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL dp_hold: tag=%0d res=%h want 7 4000000000000000", out_tag, out_result);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_tag !== 5'd8 || out_result !== 64'hFFFF_FFFF_4000_0000) begin
      errors++;
      $display("FAIL sp_box: tag=%0d res=%h want 8 ffffffff40000000", out_tag, out_result);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (fflags !== 5'b00101 || commit_count !== 16'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dp_accrue: fflags=%b commit=%0d v=%b want 00101 3 0",
               fflags, commit_count, out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      push_cfg(1'b1, 64'(i), 5'b0, 5'(i));
      tick();
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: in_ready=%b want 0", in_ready);
    end
    push_cfg(1'b1, 64'd9, 5'b0, 5'd9);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL full_reject: in_ready=%b head=%0d want 0 0", in_ready, out_tag);
    end
    // Tag 9 stays offered during the first pop; it must not slip in.
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'(j)) begin
        errors++;
        $display("FAIL full_order%0d: v=%b tag=%0d want 1 %0d", j, out_valid, out_tag, j);
      end
      in_valid  = (j == 0);
      out_ready = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || commit_count !== 16'd7) begin
      errors++;
      $display("FAIL full_drain: v=%b commit=%0d want 0 7", out_valid, commit_count);
    end
  endtask

  task automatic test_back_to_back();
    push_cfg(1'b1, 64'd20, 5'b0, 5'd20);
    tick();
    for (int i = 0; i < 10; i++) begin
      push_cfg(1'b1, 64'(21 + i), 5'b0, 5'(21 + i));
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 5'(20 + i)) begin
        errors++;
        $display("FAIL b2b%0d: v=%b rdy=%b tag=%0d want 1 1 %0d",
                 i, out_valid, in_ready, out_tag, 20 + i);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_tag !== 5'd30 || commit_count !== 16'd17 || out_result !== 64'd30) begin
      errors++;
      $display("FAIL b2b_end: tag=%0d res=%h commit=%0d want 30 1e 17",
               out_tag, out_result, commit_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || commit_count !== 16'd18) begin
      errors++;
      $display("FAIL b2b_drain: v=%b commit=%0d want 0 18", out_valid, commit_count);
    end
  endtask

  task automatic test_csr();
    push_cfg(1'b1, 64'd1, 5'b10000, 5'd1);
    tick();
    in_valid  = 1'b0;
    csr_we    = 1'b1;
    csr_wdata = 5'b00000;
    out_ready = 1'b1;
    tick();
    csr_we    = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (fflags !== 5'b10000 || commit_count !== 16'd19) begin
      errors++;
      $display("FAIL csr_pop: fflags=%b commit=%0d want 10000 19", fflags, commit_count);
    end
    csr_we    = 1'b1;
    csr_wdata = 5'b00011;
    tick();
    csr_we = 1'b0;
    checks++;
    if (fflags !== 5'b00011) begin
      errors++;
      $display("FAIL csr_write: fflags=%b want 00011", fflags);
    end
    push_cfg(1'b1, 64'd2, 5'b01000, 5'd2);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fflags !== 5'b01011 || commit_count !== 16'd20) begin
      errors++;
      $display("FAIL csr_accrue: fflags=%b commit=%0d want 01011 20", fflags, commit_count);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      push_cfg(1'b1, 64'(i), 5'b00100, 5'(i));
      tick();
    end
    push_cfg(1'b1, 64'd4, 5'b00100, 5'd4);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        fflags !== 5'b01011 || commit_count !== 16'd20) begin
      errors++;
      $display("FAIL flush: v=%b rdy=%b fflags=%b commit=%0d want 0 1 01011 20",
               out_valid, in_ready, fflags, commit_count);
    end
    push_cfg(1'b1, 64'd5, 5'b0, 5'd5);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'd5) begin
      errors++;
      $display("FAIL flush_resume: v=%b tag=%0d want 1 5", out_valid, out_tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush     = 1'b1;
    csr_we    = 1'b1;
    csr_wdata = 5'b00010;
    tick();
    flush  = 1'b0;
    csr_we = 1'b0;
    checks++;
    if (fflags !== 5'b00010 || commit_count !== 16'd21) begin
      errors++;
      $display("FAIL flush_csr: fflags=%b commit=%0d want 00010 21", fflags, commit_count);
    end
  endtask

  task automatic test_async_reset();
    push_cfg(1'b1, 64'd11, 5'b00001, 5'd11);
    tick();
    push_cfg(1'b1, 64'd12, 5'b00001, 5'd12);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: v=%b want 1", out_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        fflags !== 5'b0 || commit_count !== 16'd0) begin
      errors++;
      $display("FAIL arst: v=%b rdy=%b fflags=%b commit=%0d want 0 1 0 0",
               out_valid, in_ready, fflags, commit_count);
    end
    tick();
    rst = 1'b0;
    push_cfg(1'b0, 64'hFFFF_0000_1234_5678, 5'b0, 5'd13);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'd13 || out_result !== 64'hFFFF_FFFF_1234_5678) begin
      errors++;
      $display("FAIL arst_resume: v=%b tag=%0d res=%h want 1 13 ffffffff12345678",
               out_valid, out_tag, out_result);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_dp = 1'b0; in_result = '0;
    in_flags = '0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
    csr_we = 1'b0; csr_wdata = '0;
    tick();
    tick();
    test_reset();
    test_single();
    test_dp_and_hold();
    test_full();
    test_back_to_back();
    test_csr();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
